// File: rtl/branch_predict_unit.sv
// Branch resolution against NZV flags plus a PC-indexed table of saturating direction counters.
// Define BRANCH_STATS_EN to add saturating resolved-branch and misprediction counters.
module branch_predict_unit #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CTR_W     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [15:0]     ex_instr,
    input  logic [2:0]      ex_flags,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    output logic            br_valid,
    output logic            br_taken,
    output logic            br_mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((32'd1 << (CTR_W - 1)) - 32'd1);

    logic [CTR_W-1:0] bht_q [BHT_DEPTH];
    logic [CTR_W-1:0] bht_d [BHT_DEPTH];

    logic             br_valid_q, br_valid_d;
    logic             br_taken_q, br_taken_d;
    logic             br_mispredict_q, br_mispredict_d;

    logic [IDX_W-1:0] rd_idx_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             is_br_c;
    logic             cond_met_c;
    logic [CTR_W-1:0] wr_ctr_c;
    logic             flag_n, flag_z, flag_v;

    // Halfword-aligned PCs: bit 0 never contributes to the index.
    logic unused_bits;
    assign unused_bits = ^{if_pc, ex_pc, ex_instr};

    // Fetch lookup reads the registered table, so a same-cycle update is not bypassed.
    always_comb begin
        rd_idx_c      = if_pc[IDX_W:1];
        if_pred_taken = bht_q[rd_idx_c][CTR_W-1];
    end

    // Branch detect and condition-code evaluation.
    always_comb begin
        flag_n     = ex_flags[2];
        flag_z     = ex_flags[1];
        flag_v     = ex_flags[0];
        is_br_c    = ex_valid && (ex_instr[15:13] == 3'b110);
        cond_met_c = 1'b0;
        case (ex_instr[11:9])
            3'b000: cond_met_c = ~flag_z;
            3'b001: cond_met_c = flag_z;
            3'b010: cond_met_c = ~flag_z & ~flag_n;
            3'b011: cond_met_c = flag_n;
            3'b100: cond_met_c = flag_z | (~flag_z & ~flag_n);
            3'b101: cond_met_c = flag_n | flag_z;
            3'b110: cond_met_c = flag_v;
            3'b111: cond_met_c = 1'b1;
        endcase
    end

    // Saturating counter update for the resolving entry.
    always_comb begin
        bht_d    = bht_q;
        wr_idx_c = ex_pc[IDX_W:1];
        wr_ctr_c = bht_q[wr_idx_c];
        if (is_br_c) begin
            if (cond_met_c) begin
                if (wr_ctr_c != CTR_MAX) begin
                    wr_ctr_c = wr_ctr_c + CTR_W'(1);
                end
            end else if (wr_ctr_c != '0) begin
                wr_ctr_c = wr_ctr_c - CTR_W'(1);
            end
            bht_d[wr_idx_c] = wr_ctr_c;
        end
    end

    // Resolution report, one cycle behind the execute-stage sample.
    always_comb begin
        br_valid_d      = is_br_c;
        br_taken_d      = is_br_c & cond_met_c;
        br_mispredict_d = is_br_c & (cond_met_c ^ ex_pred_taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= CTR_INIT;
            end
            br_valid_q      <= 1'b0;
            br_taken_q      <= 1'b0;
            br_mispredict_q <= 1'b0;
        end else begin
            bht_q           <= bht_d;
            br_valid_q      <= br_valid_d;
            br_taken_q      <= br_taken_d;
            br_mispredict_q <= br_mispredict_d;
        end
    end

    assign br_valid      = br_valid_q;
    assign br_taken      = br_taken_q;
    assign br_mispredict = br_mispredict_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_br_q, stat_br_d;
    logic [15:0] stat_misp_q, stat_misp_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_br_d   = stat_br_q;
        stat_misp_d = stat_misp_q;
        if (is_br_c) begin
            if (stat_br_q != 16'hFFFF) begin
                stat_br_d = stat_br_q + 16'd1;
            end
            if ((cond_met_c != ex_pred_taken) && (stat_misp_q != 16'hFFFF)) begin
                stat_misp_d = stat_misp_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q   <= 16'd0;
            stat_misp_q <= 16'd0;
        end else begin
            stat_br_q   <= stat_br_d;
            stat_misp_q <= stat_misp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_misp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: driver queues expected {valid,taken,mispredict}, monitor compares.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic [2:0]  ex_flags;
    logic [15:0] ex_pc;
    logic        ex_pred_taken;
    logic        br_valid;
    logic        br_taken;
    logic        br_mispredict;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] exp_q [$];

    // Hand-derived taken masks per cc, bit index = {N,Z,V}.
    localparam logic [7:0] CC_MASK [8] = '{8'h33, 8'hCC, 8'h03, 8'hF0, 8'hCF, 8'hFC, 8'hAA, 8'hFF};

    branch_predict_unit #(.PC_W(16), .BHT_DEPTH(16), .CTR_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_instr      (ex_instr),
        .ex_flags      (ex_flags),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_mispredict (br_mispredict)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every negedge out of reset consumes one expectation, or requires idle outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() != 0) begin
                check("br_out", int'({br_valid, br_taken, br_mispredict}), int'(exp_q.pop_front()));
            end else begin
                check("br_idle", int'({br_valid, br_taken, br_mispredict}), 0);
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] instr, input logic [2:0] fl,
                        input logic [15:0] pc, input logic pred, input logic [2:0] exp);
        @(negedge clk);
        ex_valid      = v;
        ex_instr      = instr;
        ex_flags      = fl;
        ex_pc         = pc;
        ex_pred_taken = pred;
        @(posedge clk);
        exp_q.push_back(exp);
        #1 ex_valid = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [15:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(name, int'(if_pred_taken), int'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] m;
        rst_n = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_flags = '0;
        ex_pc = '0; ex_pred_taken = 1'b0; if_pc = '0;
        #3 rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rst_br", int'({br_valid, br_taken, br_mispredict}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int pc = 0; pc <= 16'h1E; pc += 2) lookup("rst_pred", 16'(pc), 1'b0);

        // Condition-code sweep on an entry not used later.
        for (int cc = 0; cc < 8; cc++) begin
            for (int f = 0; f < 8; f++) begin
                m = CC_MASK[cc];
                step(1'b1, 16'hC000 | (16'(cc) << 9), 3'(f), 16'h0100, 1'b0,
                     {1'b1, m[f], m[f]});
            end
        end

        // Training entry 8 (pc 0x10), starting at 01.
        lookup("train_init", 16'h0010, 1'b0);
        step(1'b1, 16'hCE00, 3'b000, 16'h0010, 1'b0, 3'b111); lookup("train_t1", 16'h0010, 1'b1);
        step(1'b1, 16'hCE00, 3'b000, 16'h0010, 1'b1, 3'b110); lookup("train_t2", 16'h0010, 1'b1);
        step(1'b1, 16'hCE00, 3'b000, 16'h0010, 1'b1, 3'b110); lookup("train_t3", 16'h0010, 1'b1);
        step(1'b1, 16'hC200, 3'b000, 16'h0010, 1'b1, 3'b101); lookup("train_n1", 16'h0010, 1'b1);
        step(1'b1, 16'hC200, 3'b000, 16'h0010, 1'b1, 3'b101); lookup("train_n2", 16'h0010, 1'b0);
        step(1'b1, 16'hC200, 3'b000, 16'h0010, 1'b0, 3'b100); lookup("train_n3", 16'h0010, 1'b0);
        step(1'b1, 16'hC200, 3'b000, 16'h0010, 1'b0, 3'b100); lookup("train_n4", 16'h0010, 1'b0);
        step(1'b1, 16'hCE00, 3'b000, 16'h0010, 1'b0, 3'b111); lookup("train_sat0_a", 16'h0010, 1'b0);
        step(1'b1, 16'hCE00, 3'b000, 16'h0010, 1'b0, 3'b111); lookup("train_sat0_b", 16'h0010, 1'b1);

        // Same-cycle read/write of entry 2: no bypass.
        @(negedge clk);
        ex_valid = 1'b1; ex_instr = 16'hCE00; ex_flags = 3'b000;
        ex_pc = 16'h0004; ex_pred_taken = 1'b0; if_pc = 16'h0004;
        #1 check("hazard_pre", int'(if_pred_taken), 0);
        @(posedge clk);
        exp_q.push_back(3'b111);
        #1 ex_valid = 1'b0;
        check("hazard_post", int'(if_pred_taken), 1);

        // Non-branch and invalid slots leave outputs at 0 and the table unchanged.
        step(1'b1, 16'h1234, 3'b000, 16'h0004, 1'b1, 3'b000); lookup("nonbr_tbl", 16'h0004, 1'b1);
        step(1'b0, 16'hC200, 3'b000, 16'h0004, 1'b1, 3'b000); lookup("invalid_tbl", 16'h0004, 1'b1);

        // Aliasing: 0x0002 and 0x0022 share index 1.
        lookup("alias_pre", 16'h0022, 1'b0);
        step(1'b1, 16'hCE00, 3'b000, 16'h0002, 1'b0, 3'b111);
        lookup("alias_22", 16'h0022, 1'b1);
        lookup("alias_02", 16'h0002, 1'b1);

        // Reset pulse restores the table and clears statistics.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst2_br", int'({br_valid, br_taken, br_mispredict}), 0);
        lookup("rst2_pc4", 16'h0004, 1'b0);
        lookup("rst2_pc10", 16'h0010, 1'b0);
        exp_q.delete();
`ifdef BRANCH_STATS_EN
        check("rst2_stat_br", int'(stat_branches), 0);
        check("rst2_stat_mp", int'(stat_mispredicts), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Five branches, two mispredicts, one non-branch in between.
        step(1'b1, 16'hCE00, 3'b000, 16'h0040, 1'b1, 3'b110);
        step(1'b1, 16'hCE00, 3'b000, 16'h0040, 1'b0, 3'b111);
        step(1'b1, 16'h1234, 3'b000, 16'h0040, 1'b1, 3'b000);
        step(1'b1, 16'hC200, 3'b000, 16'h0040, 1'b0, 3'b100);
        step(1'b1, 16'hC200, 3'b000, 16'h0040, 1'b1, 3'b101);
        step(1'b1, 16'hC600, 3'b100, 16'h0040, 1'b1, 3'b110);
`ifdef BRANCH_STATS_EN
        check("stat_br", int'(stat_branches), 5);
        check("stat_mp", int'(stat_mispredicts), 2);
`endif
        lookup("stream_pc40", 16'h0040, 1'b1);

        // Reset asserted while a resolution is being reported discards it immediately.
        step(1'b1, 16'hCE00, 3'b000, 16'h0040, 1'b0, 3'b111);
        #1 rst_n = 1'b0;
        #1 check("midrst_br", int'({br_valid, br_taken, br_mispredict}), 0);
`ifdef BRANCH_STATS_EN
        check("midrst_stat_br", int'(stat_branches), 0);
        check("midrst_stat_mp", int'(stat_mispredicts), 0);
`endif
        lookup("midrst_pc40", 16'h0040, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'hCE00, 3'b000, 16'h0040, 1'b0, 3'b111);
        lookup("post_rst_pc40", 16'h0040, 1'b1);

        repeat (3) @(negedge clk);
        #1 check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction block for the WISC-CPU pipeline. It evaluates the 3-bit condition code of conditional branches against the stored NZV flags, and keeps a direct-mapped table of saturating counters indexed by PC. Fetch reads a taken/not-taken prediction from the table; execute resolves each branch, updates the table and reports mispredictions one cycle later.

## Interface
Parameters:
- PC_W, 16, program counter width in bits
- BHT_DEPTH, 16, counter-table entries; power of two, 2 to 2^(PC_W-1)
- CTR_W, 2, saturating counter width, at least 1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_W  fetch-stage PC used for lookup
- if_pred_taken  out  1  combinational prediction: MSB of entry if_pc[IDX_W:1]
- ex_valid  in  1  execute-stage instruction is valid this cycle
- ex_instr  in  16  execute-stage instruction word
- ex_flags  in  3  stored flags {N,Z,V}
- ex_pc  in  PC_W  PC of the execute-stage instruction
- ex_pred_taken  in  1  prediction fetch made for this instruction, carried down the pipe
- br_valid  out  1  registered: a branch was resolved last cycle
- br_taken  out  1  registered resolved direction
- br_mispredict  out  1  registered: resolved direction differs from ex_pred_taken
- stat_branches  out  16  resolved-branch count (BRANCH_STATS_EN only)
- stat_mispredicts  out  16  misprediction count (BRANCH_STATS_EN only)

## Operation
- IDX_W = log2(BHT_DEPTH). The index is pc[IDX_W:1]; bit 0 is ignored because PCs are halfword-aligned.
- Branch detect: is_br = ex_valid & (ex_instr[15:13] == 3'b110).
- Condition code cc = ex_instr[11:9]. Match rules:
  - 000: ~Z
  - 001: Z
  - 010: ~Z&~N
  - 011: N
  - 100: Z | (~Z&~N)
  - 101: N|Z
  - 110: V
  - 111: 1
- Counter update at the clock edge when is_br:
  - Taken: increment, saturating at 2^CTR_W-1.
  - Not taken: decrement, saturating at 0.
- Prediction is the counter MSB (1 = taken).
- Non-branch instructions, and cycles with ex_valid=0, leave the table unchanged. They also leave br_valid, br_taken and br_mispredict at 0. This holds even if ex_pred_taken=1.
- There is no stall or back-pressure. One resolution is accepted per cycle, and back-to-back branches are each fully handled.

## Timing
- Lookup is combinational, from if_pc to if_pred_taken, within the same cycle.
- Resolution has 1-cycle latency. Inputs sampled at edge k drive br_* during cycle k+1. The table update also lands at edge k.
- Same-index read and write in the same cycle: if_pred_taken shows the pre-update value. The new value is visible from the next cycle. There is no bypass.
- Reset (asynchronous, rst_n=0), effective immediately and also mid-operation:
  - Every counter is set to weakly not-taken, 2^(CTR_W-1)-1. For CTR_W=1 this value is 0.
  - br_valid, br_taken and br_mispredict are set to 0.
  - The statistics counters are set to 0.
  - A resolution in flight when reset asserts is discarded.
- Reset release is synchronous to the next rising edge. The first resolution can be sampled at that edge.

## Configuration
- BRANCH_STATS_EN defined:
  - stat_branches increments on every edge where is_br=1.
  - stat_mispredicts increments on every edge where is_br=1 and the match result differs from ex_pred_taken.
  - Both counters saturate at 16'hFFFF and do not wrap.
- BRANCH_STATS_EN undefined:
  - stat_branches and stat_mispredicts are absent from the port list.
  - No counter flops are built.

## Test plan
- Reset check: hold rst_n=0, then release, with BHT_DEPTH=16 and CTR_W=2. Sweep if_pc over 0x0000 to 0x001E. Required: if_pred_taken=0 at every entry, and all br_* outputs are 0.
- Condition-code sweep: send ex_instr=16'hC000|(cc<<9) for all 8 cc values against all 8 NZV values, with ex_pred_taken=0. Required: br_taken one cycle later equals the match rule, and br_mispredict equals br_taken.
- Counter training: resolve 3 taken branches at ex_pc=0x0010. Required:
  - if_pc=0x0010 reads predicted-taken after the first resolution (counter 01→10).
  - The counter saturates at 11.
  - Then 1 not-taken leaves prediction 1 (11→10), and 2 not-taken give prediction 0 (10→01).
- Same-cycle hazard: if_pc=ex_pc=0x0004, entry at 01, resolve taken. Required: if_pred_taken=0 in that cycle and 1 in the next.
- Non-branch and aliasing:
  - ex_instr=16'h1234 with ex_pred_taken=1 gives br_valid=0 and br_mispredict=0, with the table unchanged.
  - Training ex_pc=0x0002 also changes the prediction for if_pc=0x0022, since both map to index 1.
- Reset mid-stream and stats (BRANCH_STATS_EN): resolve 5 branches with 2 mispredicts. Required: stat_branches=5 and stat_mispredicts=2. Asserting rst_n=0 asynchronously clears both counters and all br_* outputs before the next clock edge.
